// File: rtl/controller.sv
// controller: main decoder of the single-cycle MIPS CPU.
// Decodes opcode/function into ALU op, operand selects, register write, memory
// strobes and jal/syscall flags; all outputs are registered on clk (1-cycle latency).
// Ports: clk, rst_n (async active-low) | func[5:0], operator[5:0] in |
//        aluop[3:0], ext_16, ext_s, ext_5, regwrite, lw, jal, syscall, sw out.
module controller (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] func,
    input  logic [5:0] operator,
    output logic [3:0] aluop,
    output logic       ext_16,
    output logic       ext_s,
    output logic       ext_5,
    output logic       regwrite,
    output logic       lw,
    output logic       jal,
    output logic       syscall,
    output logic       sw
);
    logic [3:0] w_aluop;
    logic       w_ext_16, w_ext_s, w_ext_5, w_regwrite, w_lw, w_jal, w_syscall, w_sw;
    logic [3:0] r_aluop;
    logic       r_ext_16, r_ext_s, r_ext_5, r_regwrite, r_lw, r_jal, r_syscall, r_sw;

    always_comb begin
        w_aluop    = 4'd0;
        w_ext_16   = 1'b0;
        w_ext_s    = 1'b0;
        w_ext_5    = 1'b0;
        w_regwrite = 1'b0;
        w_lw       = 1'b0;
        w_jal      = 1'b0;
        w_syscall  = 1'b0;
        w_sw       = 1'b0;
        case (operator)
            6'h00: begin
                // func is only meaningful for R-type; unknown func leaves everything 0
                case (func)
                    6'h00: begin w_aluop = 4'd0;  w_ext_5 = 1'b1; w_regwrite = 1'b1; end
                    6'h03: begin w_aluop = 4'd1;  w_ext_5 = 1'b1; w_regwrite = 1'b1; end
                    6'h02: begin w_aluop = 4'd2;  w_ext_5 = 1'b1; w_regwrite = 1'b1; end
                    6'h20,
                    6'h21: begin w_aluop = 4'd5;  w_regwrite = 1'b1; end
                    6'h22: begin w_aluop = 4'd6;  w_regwrite = 1'b1; end
                    6'h24: begin w_aluop = 4'd7;  w_regwrite = 1'b1; end
                    6'h25: begin w_aluop = 4'd8;  w_regwrite = 1'b1; end
                    6'h27: begin w_aluop = 4'd10; w_regwrite = 1'b1; end
                    6'h2A: begin w_aluop = 4'd11; w_regwrite = 1'b1; end
                    6'h2B: begin w_aluop = 4'd12; w_regwrite = 1'b1; end
                    6'h0C: w_syscall = 1'b1;
                    default: ;
                endcase
            end
            6'h08,
            6'h09: begin w_aluop = 4'd5;  w_ext_16 = 1'b1; w_ext_s = 1'b1; w_regwrite = 1'b1; end
            6'h0A: begin w_aluop = 4'd11; w_ext_16 = 1'b1; w_ext_s = 1'b1; w_regwrite = 1'b1; end
            6'h0C: begin w_aluop = 4'd7;  w_ext_16 = 1'b1; w_regwrite = 1'b1; end
            6'h0D: begin w_aluop = 4'd8;  w_ext_16 = 1'b1; w_regwrite = 1'b1; end
            6'h23: begin w_aluop = 4'd5;  w_ext_16 = 1'b1; w_ext_s = 1'b1; w_regwrite = 1'b1; w_lw = 1'b1; end
            6'h2B: begin w_aluop = 4'd5;  w_ext_16 = 1'b1; w_ext_s = 1'b1; w_sw = 1'b1; end
            6'h04,
            6'h05: w_aluop = 4'd6;
            6'h03: begin w_jal = 1'b1; w_regwrite = 1'b1; end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_aluop    <= 4'd0;
            r_ext_16   <= 1'b0;
            r_ext_s    <= 1'b0;
            r_ext_5    <= 1'b0;
            r_regwrite <= 1'b0;
            r_lw       <= 1'b0;
            r_jal      <= 1'b0;
            r_syscall  <= 1'b0;
            r_sw       <= 1'b0;
        end else begin
            r_aluop    <= w_aluop;
            r_ext_16   <= w_ext_16;
            r_ext_s    <= w_ext_s;
            r_ext_5    <= w_ext_5;
            r_regwrite <= w_regwrite;
            r_lw       <= w_lw;
            r_jal      <= w_jal;
            r_syscall  <= w_syscall;
            r_sw       <= w_sw;
        end
    end

    assign aluop    = r_aluop;
    assign ext_16   = r_ext_16;
    assign ext_s    = r_ext_s;
    assign ext_5    = r_ext_5;
    assign regwrite = r_regwrite;
    assign lw       = r_lw;
    assign jal      = r_jal;
    assign syscall  = r_syscall;
    assign sw       = r_sw;
endmodule

// File: tb/tb_controller.sv
// tb_controller: randomized self-checking bench for the MIPS main decoder.
module tb_controller;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [5:0] func = 6'h00;
    logic [5:0] operator = 6'h00;
    logic [3:0] aluop;
    logic       ext_16, ext_s, ext_5, regwrite, lw, jal, syscall, sw;
    int         total = 0;
    int         bad = 0;
    logic       chk_en = 1'b0;
    logic [11:0] exp_q = 12'h000;
    logic [11:0] outs;

    controller dut (
        .clk(clk), .rst_n(rst_n), .func(func), .operator(operator),
        .aluop(aluop), .ext_16(ext_16), .ext_s(ext_s), .ext_5(ext_5),
        .regwrite(regwrite), .lw(lw), .jal(jal), .syscall(syscall), .sw(sw)
    );

    always #5 clk = ~clk;

    // packed view: {aluop, ext_16, ext_s, ext_5, regwrite, lw, jal, syscall, sw}
    assign outs = {aluop, ext_16, ext_s, ext_5, regwrite, lw, jal, syscall, sw};

    function automatic logic [11:0] pack(input int a, input bit e16, input bit es, input bit e5,
                                         input bit rw, input bit l, input bit j, input bit sc, input bit s);
        logic [3:0] a4;
        a4 = 4'(a);
        return {a4, e16, es, e5, rw, l, j, sc, s};
    endfunction

    // Instruction-table view of the decoder: what each instruction means.
    function automatic logic [11:0] model(input logic [5:0] op, input logic [5:0] fn);
        if (op == 6'h00) begin
            if (fn == 6'h00 || fn == 6'h02 || fn == 6'h03)
                return pack((fn == 6'h00) ? 0 : (fn == 6'h03) ? 1 : 2, 0, 0, 1, 1, 0, 0, 0, 0);
            if (fn == 6'h20 || fn == 6'h21) return pack(5, 0, 0, 0, 1, 0, 0, 0, 0);
            if (fn == 6'h22) return pack(6, 0, 0, 0, 1, 0, 0, 0, 0);
            if (fn == 6'h24) return pack(7, 0, 0, 0, 1, 0, 0, 0, 0);
            if (fn == 6'h25) return pack(8, 0, 0, 0, 1, 0, 0, 0, 0);
            if (fn == 6'h27) return pack(10, 0, 0, 0, 1, 0, 0, 0, 0);
            if (fn == 6'h2A) return pack(11, 0, 0, 0, 1, 0, 0, 0, 0);
            if (fn == 6'h2B) return pack(12, 0, 0, 0, 1, 0, 0, 0, 0);
            if (fn == 6'h0C) return pack(0, 0, 0, 0, 0, 0, 0, 1, 0);
            return 12'h000;
        end
        if (op == 6'h08 || op == 6'h09) return pack(5, 1, 1, 0, 1, 0, 0, 0, 0);
        if (op == 6'h0A) return pack(11, 1, 1, 0, 1, 0, 0, 0, 0);
        if (op == 6'h0C) return pack(7, 1, 0, 0, 1, 0, 0, 0, 0);
        if (op == 6'h0D) return pack(8, 1, 0, 0, 1, 0, 0, 0, 0);
        if (op == 6'h23) return pack(5, 1, 1, 0, 1, 1, 0, 0, 0);
        if (op == 6'h2B) return pack(5, 1, 1, 0, 0, 0, 0, 0, 1);
        if (op == 6'h04 || op == 6'h05) return pack(6, 0, 0, 0, 0, 0, 0, 0, 0);
        if (op == 6'h03) return pack(0, 0, 0, 0, 1, 0, 1, 0, 0);
        return 12'h000;
    endfunction

    always @(posedge clk) exp_q = rst_n ? model(operator, func) : 12'h000;
    always @(negedge rst_n) exp_q = 12'h000;

    always @(negedge clk) begin
        if (chk_en) begin
            total++;
            if (outs !== (rst_n ? exp_q : 12'h000)) begin
                bad++;
                $display("FAIL cycle op=%h fn=%h got=%h want=%h", operator, func, outs, exp_q);
            end
            total++;
            if ((32'(lw) + 32'(sw) + 32'(jal) + 32'(syscall)) > 1 || (ext_5 && ext_16)) begin
                bad++;
                $display("FAIL exclusive got=%h want=one-hot-or-zero", outs);
            end
        end
    end

    task automatic lit(input string name, input logic [11:0] want);
        total++;
        if (outs !== want) begin
            bad++;
            $display("FAIL %s got=%h want=%h", name, outs, want);
        end
    endtask

    task automatic apply(input logic [5:0] op, input logic [5:0] fn);
        @(posedge clk);
        #3;
        operator = op;
        func = fn;
    endtask

    logic [5:0] ops [0:15] = '{6'h00, 6'h00, 6'h00, 6'h08, 6'h09, 6'h0A, 6'h0C, 6'h0D,
                               6'h23, 6'h2B, 6'h04, 6'h05, 6'h02, 6'h03, 6'h00, 6'h3F};
    logic [5:0] fns [0:15] = '{6'h00, 6'h02, 6'h03, 6'h08, 6'h0C, 6'h20, 6'h21, 6'h22,
                               6'h24, 6'h25, 6'h27, 6'h2A, 6'h2B, 6'h01, 6'h3F, 6'h10};

    initial begin
        #1 lit("reset_initial", 12'h000);
        @(negedge clk);
        rst_n = 1'b1;
        chk_en = 1'b1;
        apply(6'h00, 6'h20); @(posedge clk); #1 lit("add", 12'h510);
        apply(6'h00, 6'h03); @(posedge clk); #1 lit("sra", 12'h130);
        apply(6'h00, 6'h0C); @(posedge clk); #1 lit("syscall", 12'h002);
        apply(6'h0D, 6'h00); @(posedge clk); #1 lit("ori", 12'h890);
        apply(6'h08, 6'h00); @(posedge clk); #1 lit("addi", 12'h5D0);
        apply(6'h2B, 6'h00); @(posedge clk); #1 lit("sw", 12'h5C1);
        apply(6'h23, 6'h00); @(posedge clk); #1 lit("lw", 12'h5D8);
        // asynchronous reset mid-cycle with a load decoded on the outputs
        #1 rst_n = 1'b0;
        #1 lit("reset_async", 12'h000);
        @(posedge clk); #1 lit("reset_held", 12'h000);
        @(negedge clk); #1 rst_n = 1'b1;
        #1 lit("reset_release_hold", 12'h000);
        @(posedge clk); #1 lit("reset_first_edge", 12'h5D8);
        apply(6'h00, 6'h08); @(posedge clk); #1 lit("jr", 12'h000);
        for (int o = 0; o < 64; o++) begin
            apply(6'(o), 6'h00);
            repeat (3) @(posedge clk);
            #1;
            if (o == 3) lit("sweep_jal", 12'h014);
            if (o == 1) lit("sweep_undef01", 12'h000);
            if (o == 63) lit("sweep_undef3f", 12'h000);
        end
        for (int i = 0; i < 600; i++) begin
            apply(($urandom_range(0, 3) == 0) ? 6'($urandom) : ops[$urandom_range(0, 15)],
                  ($urandom_range(0, 3) == 0) ? 6'($urandom) : fns[$urandom_range(0, 15)]);
            if ($urandom_range(0, 31) == 0) begin
                #1 rst_n = 1'b0;
                @(negedge clk); #1 rst_n = 1'b1;
            end
        end
        @(posedge clk);
        @(negedge clk);
        #1 chk_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/controller.md
# controller

Main decoder of the single-cycle MIPS CPU. Takes the instruction opcode and R-type function field and produces the ALU operation code, immediate/shift-amount operand selects, register write enable, memory load/store strobes, jal and syscall flags. Outputs are registered on the CPU clock and feed the datapath muxes, register file, data memory and the syscall/halt logic.

## Interface
- No parameters.
- clk  input  1  CPU clock; all outputs update on its rising edge.
- rst_n  input  1  asynchronous active-low reset.
- func  input  6  instruction[5:0], R-type function field.
- operator  input  6  instruction[31:26], opcode.
- aluop  output  4  ALU operation select.
- ext_16  output  1  ALU B operand = extended 16-bit immediate.
- ext_s  output  1  immediate extension: 1 = sign, 0 = zero.
- ext_5  output  1  ALU A/shift operand = 5-bit shamt (instruction[10:6]).
- regwrite  output  1  register file write enable.
- lw  output  1  memory read, write-back from memory.
- jal  output  1  link: write PC+4 to $31.
- syscall  output  1  syscall instruction.
- sw  output  1  memory write enable.

## Operation
- ALU codes: 0 SLL, 1 SRA, 2 SRL, 3 MUL, 4 DIV, 5 ADD, 6 SUB, 7 AND, 8 OR, 9 XOR, 10 NOR, 11 SLT (signed), 12 SLTU; 13-15 unused.
- func is decoded only when operator = 6'h00.
- R-type (operator 00), regwrite=1, ext_16=0, ext_s=0:
  - func 00 SLL aluop 0, ext_5=1; func 03 SRA aluop 1, ext_5=1; func 02 SRL aluop 2, ext_5=1.
  - func 20 ADD / 21 ADDU aluop 5; 22 SUB aluop 6; 24 AND 7; 25 OR 8; 27 NOR 10; 2A SLT 11; 2B SLTU 12.
  - func 08 JR: regwrite=0, aluop 0, all other outputs 0.
  - func 0C SYSCALL: syscall=1, regwrite=0, all others 0.
  - any other func: all outputs 0.
- I-type/J-type:
  - 08 ADDI, 09 ADDIU: aluop 5, ext_16=1, ext_s=1, regwrite=1.
  - 0A SLTI: aluop 11, ext_16=1, ext_s=1, regwrite=1.
  - 0C ANDI: aluop 7, ext_16=1, ext_s=0, regwrite=1.
  - 0D ORI: aluop 8, ext_16=1, ext_s=0, regwrite=1.
  - 23 LW: aluop 5, ext_16=1, ext_s=1, regwrite=1, lw=1.
  - 2B SW: aluop 5, ext_16=1, ext_s=1, sw=1, regwrite=0.
  - 04 BEQ, 05 BNE: aluop 6, all flags 0 (comparison done by ALU, branch logic external).
  - 02 J: all outputs 0.
  - 03 JAL: jal=1, regwrite=1, aluop 0, others 0.
  - any other opcode: all outputs 0.
- At most one of lw, sw, jal, syscall is 1; ext_5 and ext_16 never both 1.

## Timing
- Decode is combinational; result captured into output registers on rising clk.
- Latency: outputs reflect func/operator sampled at the previous rising edge (1 cycle).
- rst_n low: all outputs forced to 0 immediately (asynchronous), held while low.
- rst_n deassertion: first rising edge after release loads the decode of current inputs.
- Inputs changing between edges have no output effect until next edge; no glitches on outputs.

## Test plan
- Reset: rst_n=0 mid-cycle with operator=23 decoded -> all outputs 0 immediately, no clock needed.
- operator=00, func=20 -> after one edge aluop=5, regwrite=1, all other outputs 0.
- operator=00, func=03 -> aluop=1, ext_5=1, regwrite=1; func=0C -> syscall=1, regwrite=0.
- operator=0D -> aluop=8, ext_16=1, ext_s=0, regwrite=1; operator=08 -> aluop=5, ext_s=1.
- operator=23 -> lw=1, regwrite=1, aluop=5, ext_16=1, ext_s=1; operator=2B -> sw=1, regwrite=0.
- Sweep operator 00..3F with func=00, one value per 4 clocks -> operator=03 gives jal=1, regwrite=1; undefined opcodes (e.g. 01, 3F) give all outputs 0.
